// File: rtl/amux_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : amux_seq_ctrl
// Purpose  : Sequencer for an NCH-input analog multiplexer. Accepts channel
//            requests, drives break-before-make one-hot switch enables, times
//            input settling and handshakes one ADC conversion per request.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_valid/req_ready   - request handshake (ready only in IDLE)
//            req_ch, settle_cyc    - requested channel / settle cycles
//            sel, sel_onehot       - connected channel (binary / switch gates)
//            mux_en                - any switch closed
//            conv_start/conv_done  - ADC start pulse / completion pulse
//            done_valid, done_ch   - completed-conversion pulse and channel
//            err_pulse             - out-of-range request rejected
//            scan_en, scan_mask    - auto-scan controls (AMUX_AUTOSCAN_EN only)
// Config   : define AMUX_AUTOSCAN_EN to build the auto-scan ports and logic.
// Revision : 1.0 - initial release
// ============================================================================
module amux_seq_ctrl #(
    parameter int NCH      = 8,
    parameter int SELW     = 3,
    parameter int BBM_CYC  = 2,
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SELW-1:0]     req_ch,
    input  logic [SETTLE_W-1:0] settle_cyc,
    output logic [SELW-1:0]     sel,
    output logic [NCH-1:0]      sel_onehot,
    output logic                mux_en,
    output logic                conv_start,
    input  logic                conv_done,
    output logic                done_valid,
    output logic [SELW-1:0]     done_ch,
    output logic                err_pulse
`ifdef AMUX_AUTOSCAN_EN
    ,
    input  logic                scan_en,
    input  logic [NCH-1:0]      scan_mask
`endif
);

    localparam int c_BBM_W = $clog2(BBM_CYC + 1);
    localparam int c_CNT_W = (SETTLE_W > c_BBM_W) ? SETTLE_W : c_BBM_W;
    localparam logic [NCH-1:0] c_ONE = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BREAK   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CONVERT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state,      w_state_nx;
    logic [c_CNT_W-1:0]    r_cnt,        w_cnt_nx;
    logic [SELW-1:0]       r_ch,         w_ch_nx;
    logic [SETTLE_W-1:0]   r_settle,     w_settle_nx;
    logic [SELW-1:0]       r_conn_ch,    w_conn_ch_nx;
    logic                  r_conn_valid, w_conn_valid_nx;
    logic                  r_first,      w_first_nx;
    logic                  r_err,        w_err_nx;

    logic                  w_acc;
    logic [SELW-1:0]       w_acc_ch;
    logic                  w_bad_ch;

`ifdef AMUX_AUTOSCAN_EN
    logic [SELW-1:0]       r_scan_ptr;
    logic                  w_scan_hit;
    logic [SELW-1:0]       w_scan_ch;
    logic                  w_scan_go;

    // Nearest set mask bit strictly above the last scanned channel, wrapping
    // at NCH-1 -> 0 (the last scanned channel itself is tried last).
    always_comb begin : p_scan_search
        int idx;
        w_scan_hit = 1'b0;
        w_scan_ch  = '0;
        idx        = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(r_scan_ptr) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!w_scan_hit && |(scan_mask & (c_ONE << idx))) begin
                w_scan_hit = 1'b1;
                w_scan_ch  = SELW'(idx);
            end
        end
    end

    // External requests win over the self-issued scan request.
    assign w_scan_go = scan_en && !req_valid && w_scan_hit;
    assign w_acc     = (r_state == S_IDLE) && (req_valid || w_scan_go);
    assign w_acc_ch  = req_valid ? req_ch : w_scan_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Park the pointer on the top channel so the first search starts at 0.
            r_scan_ptr <= SELW'(NCH - 1);
        end else if (w_acc && !req_valid) begin
            r_scan_ptr <= w_scan_ch;
        end
    end
`else
    assign w_acc    = (r_state == S_IDLE) && req_valid;
    assign w_acc_ch = req_ch;
`endif

    // The range check only exists when the index can encode channels >= NCH.
    generate
        if ((2 ** SELW) > NCH) begin : g_range_chk
            assign w_bad_ch = (32'(w_acc_ch) >= NCH);
        end else begin : g_no_range_chk
            assign w_bad_ch = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ch         <= '0;
            r_settle     <= '0;
            r_conn_ch    <= '0;
            r_conn_valid <= 1'b0;
            r_first      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_ch         <= w_ch_nx;
            r_settle     <= w_settle_nx;
            r_conn_ch    <= w_conn_ch_nx;
            r_conn_valid <= w_conn_valid_nx;
            r_first      <= w_first_nx;
            r_err        <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_ch_nx         = r_ch;
        w_settle_nx     = r_settle;
        w_conn_ch_nx    = r_conn_ch;
        w_conn_valid_nx = r_conn_valid;
        w_first_nx      = 1'b0;
        w_err_nx        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_bad_ch) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_ch_nx     = w_acc_ch;
                        w_settle_nx = settle_cyc;
                        if (r_conn_valid && (w_acc_ch == r_conn_ch)) begin
                            // Input already connected and settled.
                            w_state_nx = S_CONVERT;
                            w_first_nx = 1'b1;
                        end else begin
                            // Open every switch before the new one may close.
                            w_state_nx      = S_BREAK;
                            w_conn_valid_nx = 1'b0;
                            w_cnt_nx        = c_CNT_W'(BBM_CYC - 1);
                        end
                    end
                end
            end
            S_BREAK: begin
                if (r_cnt == '0) begin
                    w_conn_valid_nx = 1'b1;
                    w_conn_ch_nx    = r_ch;
                    if (r_settle == '0) begin
                        w_state_nx = S_CONVERT;
                        w_first_nx = 1'b1;
                    end else begin
                        w_state_nx = S_SETTLE;
                        w_cnt_nx   = c_CNT_W'(r_settle) - 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_CONVERT;
                    w_first_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_CONVERT: begin
                if (conv_done) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Switch enables derive from a single channel register, so they can
    // never be multi-hot, even on transition cycles.
    assign sel_onehot = r_conn_valid ? (c_ONE << r_conn_ch) : '0;
    assign sel        = r_conn_ch;
    assign mux_en     = r_conn_valid;
    assign req_ready  = (r_state == S_IDLE);
    assign conv_start = (r_state == S_CONVERT) && r_first;
    assign done_valid = (r_state == S_DONE);
    assign done_ch    = r_ch;
    assign err_pulse  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_amux_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_amux_seq_ctrl
// Purpose  : Directed self-checking bench for amux_seq_ctrl (NCH=8, SELW=4,
//            BBM_CYC=2). Auto-scan scenario builds with AMUX_AUTOSCAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amux_seq_ctrl;

    localparam int NCH      = 8;
    localparam int SELW     = 4;
    localparam int BBM_CYC  = 2;
    localparam int SETTLE_W = 8;

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [SELW-1:0]     req_ch;
    logic [SETTLE_W-1:0] settle_cyc;
    logic [SELW-1:0]     sel;
    logic [NCH-1:0]      sel_onehot;
    logic                mux_en;
    logic                conv_start;
    logic                conv_done;
    logic                done_valid;
    logic [SELW-1:0]     done_ch;
    logic                err_pulse;
`ifdef AMUX_AUTOSCAN_EN
    logic                scan_en;
    logic [NCH-1:0]      scan_mask;
`endif

    int n_checks;
    int n_fail;

    amux_seq_ctrl #(
        .NCH      (NCH),
        .SELW     (SELW),
        .BBM_CYC  (BBM_CYC),
        .SETTLE_W (SETTLE_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ch     (req_ch),
        .settle_cyc (settle_cyc),
        .sel        (sel),
        .sel_onehot (sel_onehot),
        .mux_en     (mux_en),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .done_valid (done_valid),
        .done_ch    (done_ch),
        .err_pulse  (err_pulse)
`ifdef AMUX_AUTOSCAN_EN
        ,
        .scan_en    (scan_en),
        .scan_mask  (scan_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %0h want 0", sel); end
        n_checks++; if (sel_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot: got %0h want 00", sel_onehot); end
        n_checks++; if (mux_en !== 1'b0) begin n_fail++; $display("FAIL reset_mux_en: got %0b want 0", mux_en); end
        n_checks++; if ({conv_start, done_valid, err_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %03b want 000", {conv_start, done_valid, err_pulse}); end
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    endtask

    // ch3, settle 4: break cycles 1-2, settle 3-6, conv_start at 7.
    task automatic test_new_channel();
        req_valid = 1'b1; req_ch = 4'd3; settle_cyc = 8'd4;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            n_checks++; if (sel_onehot !== ((k >= 3) ? 8'h08 : 8'h00)) begin n_fail++; $display("FAIL new_onehot[%0d]: got %0h want %0h", k, sel_onehot, (k >= 3) ? 8'h08 : 8'h00); end
            n_checks++; if (mux_en !== (k >= 3)) begin n_fail++; $display("FAIL new_mux_en[%0d]: got %0b want %0b", k, mux_en, k >= 3); end
            n_checks++; if (conv_start !== (k == 7)) begin n_fail++; $display("FAIL new_conv_start[%0d]: got %0b want %0b", k, conv_start, k == 7); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL new_ready[%0d]: got %0b want 0", k, req_ready); end
            conv_done = (k == 10);
            tick();
        end
        conv_done = 1'b0;
        n_checks++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL new_done_valid: got %0b want 1", done_valid); end
        n_checks++; if (done_ch !== 4'd3) begin n_fail++; $display("FAIL new_done_ch: got %0d want 3", done_ch); end
        n_checks++; if (sel !== 4'd3) begin n_fail++; $display("FAIL new_sel: got %0d want 3", sel); end
        tick();
        n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL new_done_once: got %0b want 0", done_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL new_idle_ready: got %0b want 1", req_ready); end
        n_checks++; if (sel_onehot !== 8'h08) begin n_fail++; $display("FAIL new_switch_held: got %0h want 08", sel_onehot); end
    endtask

    // Repeat ch3: straight to CONVERT; conv_done in the conv_start cycle counts.
    task automatic test_same_channel();
        req_valid = 1'b1; req_ch = 4'd3; settle_cyc = 8'd4;
        tick();
        req_valid = 1'b0;
        n_checks++; if (conv_start !== 1'b1) begin n_fail++; $display("FAIL same_conv_start: got %0b want 1", conv_start); end
        n_checks++; if (sel_onehot !== 8'h08) begin n_fail++; $display("FAIL same_onehot1: got %0h want 08", sel_onehot); end
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        n_checks++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL same_done_valid: got %0b want 1", done_valid); end
        n_checks++; if (done_ch !== 4'd3) begin n_fail++; $display("FAIL same_done_ch: got %0d want 3", done_ch); end
        n_checks++; if (conv_start !== 1'b0) begin n_fail++; $display("FAIL same_start_once: got %0b want 0", conv_start); end
        n_checks++; if (sel_onehot !== 8'h08) begin n_fail++; $display("FAIL same_onehot2: got %0h want 08", sel_onehot); end
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_bad_channel();
        logic [SELW-1:0] bad [3];
        bad[0] = 4'd8; bad[1] = 4'd9; bad[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_ch = bad[i];
            tick();
            req_valid = 1'b0;
            n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL bad_err[%0d]: got %0b want 1", bad[i], err_pulse); end
            n_checks++; if (sel_onehot !== 8'h08 || sel !== 4'd3) begin n_fail++; $display("FAIL bad_switch[%0d]: got %0h/%0d want 08/3", bad[i], sel_onehot, sel); end
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready[%0d]: got %0b want 1", bad[i], req_ready); end
            tick();
            n_checks++; if ({err_pulse, conv_start} !== 2'b00) begin n_fail++; $display("FAIL bad_after[%0d]: got %02b want 00", bad[i], {err_pulse, conv_start}); end
        end
    endtask

    // Stray conv_done in IDLE and in SETTLE must not advance the sequence.
    task automatic test_ignore_done();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || done_valid !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: got ready=%0b dv=%0b want 1/0", req_ready, done_valid); end
        tick();
        n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL idle_done_late: got %0b want 0", done_valid); end
        req_valid = 1'b1; req_ch = 4'd1; settle_cyc = 8'd3;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_checks++; if (conv_start !== (k == 6)) begin n_fail++; $display("FAIL ign_conv_start[%0d]: got %0b want %0b", k, conv_start, k == 6); end
            n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL ign_done_valid[%0d]: got %0b want 0", k, done_valid); end
            if (k == 3) begin
                n_checks++; if (sel_onehot !== 8'h02) begin n_fail++; $display("FAIL ign_onehot: got %0h want 02", sel_onehot); end
            end
            conv_done = (k == 4) || (k == 8);
            tick();
        end
        conv_done = 1'b0;
        n_checks++; if (done_valid !== 1'b1 || done_ch !== 4'd1) begin n_fail++; $display("FAIL ign_done: got dv=%0b ch=%0d want 1/1", done_valid, done_ch); end
        tick();
    endtask

    task automatic test_settle_zero();
        req_valid = 1'b1; req_ch = 4'd6; settle_cyc = 8'd0;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_checks++; if (sel_onehot !== ((k == 3) ? 8'h40 : 8'h00)) begin n_fail++; $display("FAIL sz_onehot[%0d]: got %0h want %0h", k, sel_onehot, (k == 3) ? 8'h40 : 8'h00); end
            n_checks++; if (conv_start !== (k == 3)) begin n_fail++; $display("FAIL sz_conv_start[%0d]: got %0b want %0b", k, conv_start, k == 3); end
            conv_done = (k == 3);
            tick();
        end
        conv_done = 1'b0;
        n_checks++; if (done_valid !== 1'b1 || done_ch !== 4'd6) begin n_fail++; $display("FAIL sz_done: got dv=%0b ch=%0d want 1/6", done_valid, done_ch); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        req_valid = 1'b1; req_ch = 4'd5; settle_cyc = 8'd10;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        n_checks++; if (sel_onehot !== 8'h20) begin n_fail++; $display("FAIL rm_settle_onehot: got %0h want 20", sel_onehot); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (sel_onehot !== 8'h00 || mux_en !== 1'b0) begin n_fail++; $display("FAIL rm_open: got %0h/%0b want 00/0", sel_onehot, mux_en); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %0b want 1", req_ready); end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (conv_start || done_valid) seen++;
            tick();
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_pulses: got %0d want 0", seen); end
        // The previously connected channel is forgotten: ch5 must break again.
        req_valid = 1'b1; req_ch = 4'd5; settle_cyc = 8'd0;
        tick();
        req_valid = 1'b0;
        n_checks++; if (conv_start !== 1'b0 || sel_onehot !== 8'h00) begin n_fail++; $display("FAIL rm_rebreak: got cs=%0b oh=%0h want 0/00", conv_start, sel_onehot); end
        tick();
        tick();
        n_checks++; if (conv_start !== 1'b1) begin n_fail++; $display("FAIL rm_reconnect: got %0b want 1", conv_start); end
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        tick();
    endtask

`ifdef AMUX_AUTOSCAN_EN
    task automatic test_autoscan();
        logic [SELW-1:0] exp_ch [7];
        int   got;
        logic prev_ready;
        exp_ch[0] = 4'd0; exp_ch[1] = 4'd2; exp_ch[2] = 4'd7; exp_ch[3] = 4'd0;
        exp_ch[4] = 4'd2; exp_ch[5] = 4'd4; exp_ch[6] = 4'd7;
        got = 0;
        scan_mask = 8'h85; settle_cyc = 8'd1; conv_done = 1'b1; scan_en = 1'b1;
        for (int c = 0; c < 400 && got < 7; c++) begin
            prev_ready = req_ready;
            tick();
            if (req_valid && prev_ready) req_valid = 1'b0;
            if (done_valid) begin
                n_checks++; if (done_ch !== exp_ch[got]) begin n_fail++; $display("FAIL scan_ch[%0d]: got %0d want %0d", got, done_ch, exp_ch[got]); end
                got++;
                if (got == 5) begin
                    req_valid = 1'b1; req_ch = 4'd4;
                end
            end
        end
        n_checks++; if (got != 7) begin n_fail++; $display("FAIL scan_timeout: got %0d dones want 7", got); end
        scan_en = 1'b0; conv_done = 1'b0; req_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask
`endif

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_ch     = '0;
        settle_cyc = '0;
        conv_done  = 1'b0;
`ifdef AMUX_AUTOSCAN_EN
        scan_en    = 1'b0;
        scan_mask  = '0;
`endif
        test_reset();
        test_new_channel();
        test_same_channel();
        test_bad_channel();
        test_ignore_done();
        test_settle_zero();
        test_reset_mid();
`ifdef AMUX_AUTOSCAN_EN
        test_autoscan();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
